// File: rtl/program_loader_pkg.sv
// ============================================================================
//  Module      : program_loader_pkg
//  Description : Shared state encoding and header limits for program_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [31:0] IM_DEPTH = 32'd256;
    localparam logic [31:0] MIN_HDR  = 32'd1;
    localparam logic [31:0] MAX_HDR  = 32'd256;

endpackage

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
//  Module      : program_loader
//  Description : Streams a header-prefixed program into instruction memory,
//                then releases the processor with a one-cycle start pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter int reg_width = 12,
    parameter int Im_width  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [reg_width-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                reload,
    output logic [Im_width-1:0] im_address,
    output logic [reg_width-1:0] im_data,
    output logic                im_wren,
    output logic                start,
    output logic                cpu_hold,
    output logic                error,
    output logic [Im_width:0]   words_loaded
);

    state_t              state;
    state_t              state_next;
    logic                ready_en;
    logic [Im_width:0]   addr;
    logic [Im_width:0]   target;
    logic [Im_width:0]   addr_inc;
    logic [31:0]         hdr_val;
    logic                can_accept;
    logic                xfer;
    logic                hdr_ok;
    logic                last_word;

    // ready_en keeps in_ready low until the first edge after reset release
    assign can_accept = ready_en && !reload && (state == ST_IDLE || state == ST_LOAD);
    assign xfer       = in_valid && can_accept;
    assign hdr_val    = 32'(in_data);
    assign hdr_ok     = (hdr_val >= MIN_HDR) && (hdr_val <= MAX_HDR);
    assign addr_inc   = addr + {{Im_width{1'b0}}, 1'b1};
    assign last_word  = (addr_inc == target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = can_accept;
        cpu_hold   = (state != ST_DONE);
        error      = (state == ST_ERROR);
        if (reload) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (xfer) state_next = hdr_ok ? ST_LOAD : ST_ERROR;
                ST_LOAD:  if (xfer && last_word) state_next = ST_START;
                ST_START: state_next = ST_DONE;
                default:  state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en     <= 1'b0;
            addr         <= '0;
            target       <= '0;
            im_wren      <= 1'b0;
            im_address   <= '0;
            im_data      <= '0;
            start        <= 1'b0;
            words_loaded <= '0;
        end else begin
            ready_en <= 1'b1;
            im_wren  <= 1'b0;
            // start lands one cycle after START, i.e. after the last write is visible
            start    <= (state == ST_START) && !reload;
            if (reload) begin
                words_loaded <= '0;
            end else if (xfer && state == ST_IDLE) begin
                if (hdr_ok) begin
                    target       <= in_data[Im_width:0];
                    addr         <= '0;
                    words_loaded <= '0;
                end
            end else if (xfer && state == ST_LOAD) begin
                im_wren      <= 1'b1;
                im_address   <= addr[Im_width-1:0];
                im_data      <= in_data;
                addr         <= addr_inc;
                words_loaded <= words_loaded + {{Im_width{1'b0}}, 1'b1};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
//  Module      : tb_program_loader
//  Description : Directed bench for program_loader with a per-cycle reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam int RW = 12;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic [AW-1:0] im_address;
    logic [RW-1:0] im_data;
    logic          im_wren;
    logic          start;
    logic          cpu_hold;
    logic          error;
    logic [AW:0]   words_loaded;

    program_loader #(.reg_width(RW), .Im_width(AW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .im_address(im_address),
        .im_data(im_data), .im_wren(im_wren), .start(start),
        .cpu_hold(cpu_hold), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: 0 idle, 1 loading, 2 start-phase, 3 done, 4 error
    int m_mode = 0, m_n = 0, m_k = 0, m_addr = 0, m_data = 0, m_wl = 0;
    bit m_wren = 0, m_start = 0, m_ren = 0;

    function automatic bit m_ready();
        return m_ren && (m_mode == 0 || m_mode == 1) && !reload && !reset;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit x;
        if (reset) begin
            m_mode = 0; m_n = 0; m_k = 0; m_addr = 0; m_data = 0; m_wl = 0;
            m_wren = 0; m_start = 0; m_ren = 0;
        end else begin
            x = in_valid && m_ready();
            m_wren  = 0;
            m_start = (m_mode == 2) && !reload;
            if (reload) begin
                m_mode = 0;
                m_wl   = 0;
            end else if (m_mode == 0 && x) begin
                if (int'(in_data) >= 1 && int'(in_data) <= 256) begin
                    m_n = int'(in_data); m_k = 0; m_wl = 0; m_mode = 1;
                end else begin
                    m_mode = 4;
                end
            end else if (m_mode == 1 && x) begin
                m_wren = 1; m_addr = m_k; m_data = int'(in_data);
                m_k++; m_wl = m_k;
                if (m_k == m_n) m_mode = 2;
            end else if (m_mode == 2) begin
                m_mode = 3;
            end
            m_ren = 1;
        end
    end

    int wa[$];
    int wd[$];
    int wc[$];
    int start_cnt = 0;
    int start_cyc = 0;

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(m_ready()));
        chk("im_wren", int'(im_wren), int'(m_wren));
        chk("im_address", int'(im_address), m_addr);
        chk("im_data", int'(im_data), m_data);
        chk("start", int'(start), int'(m_start));
        chk("cpu_hold", int'(cpu_hold), int'(m_mode != 3));
        chk("error", int'(error), int'(m_mode == 4));
        chk("words_loaded", int'(words_loaded), m_wl);
        if (im_wren) begin
            wa.push_back(int'(im_address));
            wd.push_back(int'(im_data));
            wc.push_back(cyc);
        end
        if (start) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [RW-1:0] w);
        int tries;
        bit ok;
        tries = 0;
        ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!ok && tries < 50) begin
            #1;
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete();
        start_cnt = 0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick(1);
        reload = 1'b0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1);
    end

    initial begin
        int ok_all;
        reset = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = '0;
        tick(2);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_cpu_hold", int'(cpu_hold), 1);
        chk("rst_words", int'(words_loaded), 0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready_before_edge", int'(in_ready), 0);
        tick(1);
        chk("rel_in_ready_after_edge", int'(in_ready), 1);

        // Three back-to-back words
        clear_log();
        send(12'd3); send(12'h111); send(12'h222); send(12'h333);
        tick(4);
        chk("t1_nwrites", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("t1_w0", (wa[0] << 12) | wd[0], 12'h111);
            chk("t1_w1", (wa[1] << 12) | wd[1], (1 << 12) | 12'h222);
            chk("t1_w2", (wa[2] << 12) | wd[2], (2 << 12) | 12'h333);
            chk("t1_consecutive", wc[2] - wc[0], 2);
            chk("t1_start_delay", start_cyc - wc[2], 1);
        end
        chk("t1_starts", start_cnt, 1);
        chk("t1_words", int'(words_loaded), 3);
        chk("t1_cpu_hold", int'(cpu_hold), 0);
        chk("t1_done_ready", int'(in_ready), 0);
        do_reload();
        chk("t1_reload_words", int'(words_loaded), 0);

        // Full 256-word image with random gaps
        clear_log();
        send(12'd256);
        for (int i = 0; i < 256; i++) begin
            tick($urandom_range(0, 2));
            send(RW'((i * 37 + 5) & 12'hFFF));
        end
        tick(4);
        chk("t2_nwrites", wa.size(), 256);
        ok_all = 1;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] != i || wd[i] != ((i * 37 + 5) & 12'hFFF)) ok_all = 0;
        chk("t2_order", ok_all, 1);
        chk("t2_starts", start_cnt, 1);
        chk("t2_words", int'(words_loaded), 256);
        do_reload();

        // Bad headers: 0 and 0x101
        clear_log();
        send(12'd0);
        tick(2);
        chk("t3a_error", int'(error), 1);
        chk("t3a_ready", int'(in_ready), 0);
        do_reload();
        chk("t3a_cleared", int'(error), 0);
        send(12'h101);
        tick(2);
        chk("t3b_error", int'(error), 1);
        chk("t3b_ready", int'(in_ready), 0);
        chk("t3_no_writes", wa.size(), 0);
        chk("t3_no_start", start_cnt, 0);
        do_reload();
        chk("t3b_cleared", int'(error), 0);

        // Reload coinciding with a valid word mid-load
        clear_log();
        send(12'd5); send(12'h001); send(12'h002);
        reload = 1'b1; in_valid = 1'b1; in_data = 12'h999;
        tick(1);
        reload = 1'b0; in_valid = 1'b0;
        tick(2);
        chk("t4_nwrites", wa.size(), 2);
        chk("t4_no_start", start_cnt, 0);
        chk("t4_words", int'(words_loaded), 0);
        clear_log();
        send(12'd1); send(12'hABC);
        tick(3);
        chk("t4b_nwrites", wa.size(), 1);
        if (wa.size() == 1) chk("t4b_w0", (wa[0] << 12) | wd[0], 12'hABC);
        chk("t4b_starts", start_cnt, 1);
        do_reload();

        // Asynchronous reset between edges during a load
        send(12'd4); send(12'h055);
        in_valid = 1'b1; in_data = 12'h066;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_wren", int'(im_wren), 0);
        chk("t5_cpu_hold", int'(cpu_hold), 1);
        chk("t5_words", int'(words_loaded), 0);
        chk("t5_addr", int'(im_address), 0);
        chk("t5_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        tick(2);
        clear_log();
        reset = 1'b0;
        tick(3);
        chk("t5_no_writes", wa.size(), 0);
        chk("t5_idle_ready", int'(in_ready), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
